// File: rtl/mem_pkg.sv
// Shared definitions for the pipelined memory.
// Holds the default parameter values, the legal read-latency range, the
// response record layout {rdata, err} and a helper that derives the
// response-buffer depth from the read latency.
package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 16384;
    localparam int DEF_RD_LAT = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Response record. The top module carries the same field order
    // ({rdata, err}, err in the LSB) at its own DATA_W.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

    // One buffer slot per pipeline stage plus one, so a full pipeline can
    // drain into the buffer while the consumer stalls.
    function automatic int rsp_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous response FIFO with fall-through behaviour.
// When empty, the input is presented directly at the output so an arriving
// response costs no extra cycle; it is only written into the buffer if the
// consumer does not take it in the same cycle.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake, in_data payload
//   out_valid/out_ready  consumer handshake, out_data payload
module rsp_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : buf_q[rd_ptr_q];

    // An arrival that bypasses straight to a ready consumer is not stored.
    assign push = in_valid && !full && !(empty && out_ready);
    assign pop  = out_ready && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipelined_memory.sv
// Single-port word memory behind a valid/ready request channel and an
// in-order valid/ready response channel with RD_LAT cycles of latency.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write, req_addr,
//   req_wdata, req_be            request payload (be used on writes only)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           read data (0 for writes/errors), range error
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int RSP_DEPTH = rsp_depth(RD_LAT);
    localparam int NBYTES    = DATA_W / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int RSP_W     = DATA_W + 1;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("pipelined_memory: DATA_W must be a multiple of 8");
    end
    if (DEPTH > 2 ** ADDR_W) begin : g_bad_depth
        $error("pipelined_memory: DEPTH exceeds the address space");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("pipelined_memory: RD_LAT outside 1..4");
    end

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              rsp_hs;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    assign accept   = req_valid && req_ready;
    assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign idx      = req_addr[IDX_W-1:0];
    assign rsp_hs   = rsp_valid && rsp_ready;

    // Storage (no reset). The read port samples on the acceptance edge; no
    // write can land on that same edge since only one request is accepted
    // per cycle, so the sampled word already reflects every earlier write.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (accept && req_write && in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (req_be[b]) begin
                    mem_q[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
        rd_data_q <= mem_q[idx];
    end

    // Stage 1 control travels alongside the registered read data.
    logic s1_valid_q;
    logic s1_read_q;
    logic s1_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_read_q  <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_read_q  <= accept && !req_write && in_range;
            s1_err_q   <= accept && !in_range;
        end
    end

    logic             stg_valid [1:RD_LAT];
    logic [RSP_W-1:0] stg_rsp   [1:RD_LAT];

    assign stg_valid[1] = s1_valid_q;
    assign stg_rsp[1]   = {(s1_read_q ? rd_data_q : '0), s1_err_q};

    // Extra delay stages so the response reaches the buffer input in the
    // RD_LAT-th cycle after acceptance.
    genvar gi;
    for (gi = 2; gi <= RD_LAT; gi++) begin : g_stage
        logic             valid_q;
        logic [RSP_W-1:0] rsp_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                rsp_q   <= '0;
            end else begin
                valid_q <= stg_valid[gi-1];
                rsp_q   <= stg_rsp[gi-1];
            end
        end

        assign stg_valid[gi] = valid_q;
        assign stg_rsp[gi]   = rsp_q;
    end

    logic             fifo_in_ready;
    logic             fifo_out_valid;
    logic [RSP_W-1:0] fifo_out_data;

    rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (stg_valid[RD_LAT]),
        .in_ready  (fifo_in_ready),
        .in_data   (stg_rsp[RD_LAT]),
        .out_valid (fifo_out_valid),
        .out_ready (rsp_ready),
        .out_data  (fifo_out_data)
    );

    assign rsp_valid = fifo_out_valid;
    assign rsp_rdata = fifo_out_valid ? fifo_out_data[RSP_W-1:1] : '0;
    assign rsp_err   = fifo_out_valid && fifo_out_data[0];

    // Outstanding = accepted but not yet handshaken on the response side.
    // The buffer can hold every outstanding response, so its in_ready is
    // never the limiting term in practice.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !rsp_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp_hs && !accept) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign req_ready = reset_n && (cnt_q < CNT_W'(RSP_DEPTH)) && fifo_in_ready;

endmodule

// File: tb/tb_pipelined_memory.sv
module tb_pipelined_memory;
    import mem_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;
    localparam int RSPD   = RD_LAT + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [1:0]        req_be = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    pipelined_memory #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a plain word array plus a queue of expected responses
    // in acceptance order.
    typedef struct {
        rsp_t rsp;
        int   acc;
    } exp_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    exp_t              sb [$];

    int                cyc = 0;
    int                last_hs = -100;
    bit                head_seen = 0;
    int                max_cnt = 0;
    int                hs_cnt = 0;
    int                first_hs = 0;
    logic [DATA_W-1:0] last_rdata = '0;
    logic              last_err = 1'b0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_rdata = '0;
    logic              prev_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_err", rsp_err, 0);
            sb.delete();
            head_seen  = 0;
            prev_valid = 1'b0;
        end else begin
            check("req_ready", req_ready, (sb.size() < RSPD));
            if (sb.size() > max_cnt) max_cnt = sb.size();
            if (prev_valid && !prev_ready) begin
                check("stable_valid", rsp_valid, 1);
                check("stable_rdata", rsp_rdata, prev_rdata);
                check("stable_err", rsp_err, prev_err);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp", rsp_valid, 0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1;
                        if (last_hs < sb[0].acc + RD_LAT)
                            check("latency", cyc - sb[0].acc, RD_LAT);
                    end
                    if (rsp_ready) begin
                        check("rsp_rdata", rsp_rdata, sb[0].rsp.rdata);
                        check("rsp_err", rsp_err, sb[0].rsp.err);
                        last_rdata = rsp_rdata;
                        last_err   = rsp_err;
                        void'(sb.pop_front());
                        head_seen = 0;
                        last_hs   = cyc;
                        if (hs_cnt == 0) first_hs = cyc;
                        hs_cnt++;
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_t e;
                e.acc = cyc;
                e.rsp.rdata = '0;
                e.rsp.err   = 1'b0;
                if (int'(req_addr) >= DEPTH) begin
                    e.rsp.err = 1'b1;
                end else if (req_write) begin
                    for (int b = 0; b < 2; b++)
                        if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else begin
                    e.rsp.rdata = ref_mem[req_addr];
                end
                sb.push_back(e);
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    task automatic send(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [1:0] be);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("[TB] req w=%0d addr=%0d wdata=%h be=%b", w, a, d, be);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);
        @(posedge clk);
        #1;

        // Known contents for every in-range word.
        for (int i = 0; i < DEPTH; i++)
            send(1'b1, ADDR_W'(i), DATA_W'($urandom), 2'b11);
        drain();

        // Write then read in the next cycle.
        send(1'b1, 8'd3, 16'hBEEF, 2'b11);
        send(1'b0, 8'd3, 16'h0, 2'b00);
        drain();
        check("beef_read", last_rdata, 16'hBEEF);

        // Partial byte-enable write.
        send(1'b1, 8'd5, 16'h1234, 2'b11);
        send(1'b1, 8'd5, 16'hABCD, 2'b01);
        send(1'b0, 8'd5, 16'h0, 2'b00);
        drain();
        check("be_merge", last_rdata, 16'h12CD);

        // Stall the consumer: three accepted, fourth held off.
        rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'b0, ADDR_W'(i), 16'h0, 2'b00);
            end
            begin
                repeat (5) @(negedge clk);
                check("full_req_ready", req_ready, 0);
                check("full_count", sb.size(), RSPD);
                check("full_rsp_valid", rsp_valid, 1);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Out-of-range read and write.
        send(1'b0, 8'd20, 16'h0, 2'b00);
        drain();
        check("oor_read_err", last_err, 1);
        check("oor_read_data", last_rdata, 0);
        send(1'b1, 8'd17, 16'hFFFF, 2'b11);
        drain();
        check("oor_write_err", last_err, 1);
        send(1'b0, 8'd1, 16'h0, 2'b00);
        drain();
        check("addr1_unchanged", last_rdata, ref_mem[1]);

        // Full throughput.
        max_cnt = 0;
        hs_cnt  = 0;
        for (int i = 0; i < 10; i++) send(1'b0, ADDR_W'(i), 16'h0, 2'b00);
        drain();
        check("thru_count", hs_cnt, 10);
        check("thru_span", last_hs - first_hs, 9);
        check("thru_max_cnt", (max_cnt <= 2), 1);

        // Reset with two responses outstanding.
        rsp_ready = 1'b0;
        send(1'b0, 8'd3, 16'h0, 2'b00);
        send(1'b0, 8'd5, 16'h0, 2'b00);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_drop_valid", rsp_valid, 0);
        check("rst_drop_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale", sb.size(), 0);
        send(1'b0, 8'd3, 16'h0, 2'b00);
        drain();
        check("persist_3", last_rdata, 16'hBEEF);
        send(1'b0, 8'd5, 16'h0, 2'b00);
        drain();
        check("persist_5", last_rdata, 16'h12CD);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom);
            req_addr  = ADDR_W'($urandom_range(0, 19));
            req_wdata = DATA_W'($urandom);
            req_be    = 2'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        $display("[TB] random phase done, %0d responses handshaken", hs_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_memory.md
PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, request address width.
REQ-003 Parameter DEPTH, default 16384, number of DATA_W-bit words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, request-to-response latency in cycles; legal range 1..4.
REQ-005 Localparam RSP_DEPTH = RD_LAT+1, response buffer entries and maximum outstanding requests.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 req_be  input  DATA_W/8  byte enables for writes; ignored on reads.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts the response when high together with rsp_valid.
REQ-016 rsp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-017 rsp_err  output  1  request address was out of range.

Function
REQ-018 Accept = req_valid && req_ready; at most one request per cycle; single shared storage port.
REQ-019 Every accepted request, read or write, SHALL produce exactly one response, in acceptance order.
REQ-020 Outstanding count = accepted requests not yet handshaken on the response side; req_ready = (count < RSP_DEPTH).
REQ-021 count SHALL increment on accept, decrement on response handshake, and stay unchanged when both occur in the same cycle.
REQ-022 Write accepted at edge E SHALL update the enabled bytes of storage at E; bytes whose req_be bit is 0 are unchanged.
REQ-023 Read accepted at edge E SHALL return storage contents as of after E, so a read accepted one cycle after a write to the same address returns the new data.
REQ-024 With an empty response buffer and rsp_ready high, a response SHALL become valid exactly RD_LAT cycles after its acceptance edge.
REQ-025 rsp_valid, rsp_rdata and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 With rsp_ready held low, responses SHALL accumulate up to RSP_DEPTH; none SHALL be dropped or duplicated.
REQ-027 With req_valid and rsp_ready both held high, one request SHALL be accepted and one response delivered per cycle (full throughput).
REQ-028 req_addr >= DEPTH: writes SHALL be suppressed, reads SHALL return rsp_rdata = 0, and the response SHALL carry rsp_err = 1.
REQ-029 Storage contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-030 While reset_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, count=0.
REQ-031 Assertion mid-operation SHALL discard all in-flight and buffered responses immediately; writes already performed SHALL persist.
REQ-032 req_ready SHALL be 1 in the first cycle after reset_n deasserts.

Structure
REQ-033 Package mem_pkg SHALL hold the default parameter values, RD_LAT bounds, and a response record type {rdata, err}.
REQ-034 Response buffering SHALL be a sub-module rsp_fifo, a parametrised synchronous FIFO with depth RSP_DEPTH and valid/ready ports.
REQ-035 An elaboration-time check SHALL reject DATA_W%8 != 0, DEPTH > 2**ADDR_W, and RD_LAT outside 1..4.

Verification (DATA_W=16, DEPTH=16, RD_LAT=2, RSP_DEPTH=3)
REQ-036 Write addr 3 = 0xBEEF with be=11, then read addr 3 in the next cycle -> write response err=0 rdata=0; read response rdata=0xBEEF valid exactly 2 cycles after its acceptance.
REQ-037 Write addr 5 = 0x1234, then write addr 5 = 0xABCD with be=01, then read addr 5 -> rdata=0x12CD.
REQ-038 rsp_ready=0 with reads of addrs 0,1,2,3 offered back-to-back -> 3 accepted, req_ready=0 on the 4th; rsp_ready=1 -> three responses in order, then the 4th request is accepted.
REQ-039 Read addr 20, then write addr 17 = 0xFFFF -> both responses err=1, read rdata=0; a subsequent read of addr 1 is unchanged from its prior value.
REQ-040 req_valid=rsp_ready=1 for 10 reads -> 10 responses on consecutive cycles, count never exceeds 2.
REQ-041 reset_n pulsed low with 2 responses outstanding -> rsp_valid drops immediately and no stale response appears after release; previously written data is still readable.
